// File: rtl/str2num_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | str2num_if : byte-stream input and result bundle for str2num          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface str2num_if #(
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] num_out;
    logic                  num_valid;
    logic                  num_ovf;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, num_out, num_valid, num_ovf
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, num_out, num_valid, num_ovf
    );
endinterface
`default_nettype wire

// File: rtl/str2num.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | str2num : streaming ASCII-decimal to saturating unsigned binary       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module str2num #(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    str2num_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    ovf;
    logic [DATA_WIDTH-1:0]   num_out_r;
    logic                    num_valid_r;
    logic                    num_ovf_r;

    logic                    ready;
    logic                    accept;
    logic                    is_digit;
    logic                    is_blank;
    logic [3:0]              digit;
    logic [DATA_WIDTH+3:0]   acc_wide;
    logic [DATA_WIDTH+3:0]   acc_next;
    logic                    acc_too_big;

    assign ready    = (state != DONE);
    assign accept   = bus.rx_valid && ready;
    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_blank = (bus.rx_data == 8'hFF);
    // ASCII digits occupy 0x30-0x39, so the low nibble is the value
    assign digit    = bus.rx_data[3:0];

    assign acc_wide    = {4'b0000, acc};
    assign acc_next    = (acc_wide << 3) + (acc_wide << 1)
                       + {{DATA_WIDTH{1'b0}}, digit};
    assign acc_too_big = |acc_next[DATA_WIDTH+3:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            num_out_r   <= '0;
            num_valid_r <= 1'b0;
            num_ovf_r   <= 1'b0;
        end else begin
            num_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_digit) begin
                        acc   <= {{(DATA_WIDTH-4){1'b0}}, digit};
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept && !is_blank) begin
                        if (is_digit) begin
                            // Saturation is sticky for the rest of this number
                            if (ovf || acc_too_big) begin
                                acc <= '1;
                                ovf <= 1'b1;
                            end else begin
                                acc <= acc_next[DATA_WIDTH-1:0];
                            end
                        end else begin
                            num_out_r   <= acc;
                            num_ovf_r   <= ovf;
                            num_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready  = ready;
    assign bus.num_out   = num_out_r;
    assign bus.num_valid = num_valid_r;
    assign bus.num_ovf   = num_ovf_r;
endmodule
`default_nettype wire

// File: tb/tb_str2num.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_str2num : randomized self-checking bench for str2num               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_str2num;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    str2num_if #(.DATA_WIDTH(DW)) bus ();

    str2num #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: digits of the number being received, plus expected outputs
    int unsigned     dq[$];
    logic            exp_pending = 1'b0;
    logic [DW-1:0]   exp_out     = '0;
    logic            exp_ovf     = 1'b0;

    logic [7:0] terms [9] = '{8'h20, 8'h2C, 8'h0D, 8'h0A, 8'h3B, 8'h41, 8'h00, 8'h2F, 8'h3A};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void eval_digits(output logic [DW-1:0] v, output logic o);
        longint unsigned x;
        longint unsigned maxv;
        maxv = (64'd1 << DW) - 64'd1;
        x = 0;
        o = 1'b0;
        foreach (dq[i]) begin
            x = x * 10 + longint'(dq[i]);
            if (x > maxv) begin
                x = maxv;
                o = 1'b1;
            end
        end
        v = x[DW-1:0];
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [DW-1:0] v;
        logic          o;
        if (b >= 8'h30 && b <= 8'h39) begin
            dq.push_back(int'(b) - 48);
        end else if (b != 8'hFF && dq.size() > 0) begin
            eval_digits(v, o);
            exp_out     = v;
            exp_ovf     = o;
            exp_pending = 1'b1;
            dq.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  64'(bus.rx_ready),  64'd1);
        check({tag, "_num_valid"}, 64'(bus.num_valid), 64'd0);
        check({tag, "_num_out"},   64'(bus.num_out),   64'd0);
        check({tag, "_num_ovf"},   64'(bus.num_ovf),   64'd0);
    endtask

    // One clock: check outputs mid-cycle, record the handshake, advance
    task automatic step(output bit accepted);
        @(negedge clk);
        check("rx_ready",  64'(bus.rx_ready),  64'(!exp_pending));
        check("num_valid", 64'(bus.num_valid), 64'(exp_pending));
        check("num_out",   64'(bus.num_out),   64'(exp_out));
        check("num_ovf",   64'(bus.num_ovf),   64'(exp_ovf));
        exp_pending = 1'b0;
        accepted = bus.rx_valid && bus.rx_ready;
        if (accepted) model_byte(bus.rx_data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        bus.rx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.rx_data = 8'($urandom);
            step(a);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit acc;
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        idle(gap);
        acc = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 8 && !acc; i++) step(acc);
        check("accept_timeout", 64'(acc), 64'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], max_gap);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        #1 check_reset_values("async_rst");
        dq.delete();
        exp_pending = 1'b0;
        exp_out     = '0;
        exp_ovf     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_values("hold_rst");
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset");
        rst_n = 1'b1;
        idle(2);

        send_str("123\r", 0);
        idle(2);
        send_str("0\n", 0);
        send_str("4294967295 ", 0);
        send_str("4294967296,", 0);
        send_str("99999999999\r", 0);
        send_str("5\r", 0);
        idle(1);

        send_str(" ,\r", 0);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_str("007", 0);
        send_byte(8'hFF, 0);
        send_str(";", 0);
        idle(1);

        // valid toggling, then a byte presented during the result bubble
        idle(1); send_byte("4", 0);
        idle(1); send_byte("2", 0);
        idle(1); send_byte(8'h0A, 0);
        send_str("7\r", 0);
        idle(2);

        send_str("98", 0);
        apply_reset();
        send_str("5\r", 0);
        idle(2);

        for (int n = 0; n < 60; n++) begin
            int gap;
            int len;
            gap = int'($urandom_range(2, 0));
            for (int k = 0; k < int'($urandom_range(2, 0)); k++)
                send_byte(($urandom_range(3, 0) == 0) ? 8'hFF : terms[$urandom_range(8, 0)], gap);
            len = int'($urandom_range(12, 1));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(5, 0) == 0) send_byte(8'hFF, gap);
                send_byte(8'(8'h30 + $urandom_range(9, 0)), gap);
            end
            send_byte(terms[$urandom_range(8, 0)], gap);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
